logic_sweep_ctrl: RTL and testbench

Sequencer for the 5-input gate-level combinational test circuits (inputs a..e, single output z).
- Drives every input pattern in ascending order and waits a programmable settle time.
- Samples z into a truth-table register and compares it against an expected table.
- Sits between the simulator's stimulus/check harness and one combinational circuit instance; one sweep per start request.

---
 rtl/logic_sweep_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_logic_sweep_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl: truth-table sweep sequencer for one N_IN-input combinational circuit.
//
// For each sweep, the controller drives every input vector in ascending order. It holds each
// vector for SETTLE cycles, samples the circuit output into a truth-table register and
// compares that bit against an expected table captured when the sweep starts.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start_i        level-sampled sweep request, only acted on in idle
//   abort_i        cancels a sweep in progress (wins over start_i in idle)
//   exp_table_i    expected z per vector index, captured when start is accepted
//   dut_z_i        output of the controlled circuit
//   stim_out_o     input vector driven to the circuit (bit0 = a ... bit4 = e)
//   busy_o         high while settling/sampling
//   done_o         one-cycle pulse at sweep completion
//   truth_table_o  captured z, bit v = z for vector v
//   ones_count_o   number of 1 bits in truth_table_o
//   mismatch_cnt_o number of vectors where captured z != expected
//   first_fail_o   lowest failing vector index, 0 if none
//   mismatch_o     mismatch_cnt_o != 0, updated at sweep completion only
module logic_sweep_ctrl #(
  parameter int unsigned N_IN   = 5,
  parameter int unsigned SETTLE = 2,
  localparam int unsigned TT_W  = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [TT_W-1:0] exp_table_i,
  input  logic            dut_z_i,
  output logic [N_IN-1:0] stim_out_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [TT_W-1:0] truth_table_o,
  output logic [N_IN:0]   ones_count_o,
  output logic [N_IN:0]   mismatch_cnt_o,
  output logic [N_IN-1:0] first_fail_o,
  output logic            mismatch_o
);

  localparam int unsigned CntW = N_IN + 1;
  localparam logic [7:0] SettleLoad = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] VecLast = N_IN'(TT_W - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [TT_W-1:0] exp_q, exp_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic [CntW-1:0] ones_q, ones_d;
  logic [CntW-1:0] mcnt_q, mcnt_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            mism_q, mism_d;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    mcnt_d  = mcnt_q;
    ff_d    = ff_q;
    mism_d  = mism_q;
    // done is registered one cycle behind the DONE state so the pulse lands in the
    // cycle the FSM is already back in idle.
    done_d  = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        stim_d = '0;
        busy_d = 1'b0;
        if (start_i && !abort_i) begin
          tt_d    = '0;
          ones_d  = '0;
          mcnt_d  = '0;
          ff_d    = '0;
          exp_d   = exp_table_i;
          vec_d   = '0;
          cnt_d   = SettleLoad;
          busy_d  = 1'b1;
          state_d = StSettle;
        end
      end

      StSettle: begin
        if (abort_i) begin
          stim_d  = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == 8'd0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      StSample: begin
        // The sample is taken even when aborting so partial results include this vector.
        tt_d[vec_q] = dut_z_i;
        ones_d      = ones_q + CntW'(dut_z_i);
        if (dut_z_i != exp_q[vec_q]) begin
          mcnt_d = mcnt_q + CntW'(1);
          if (mcnt_q == '0) begin
            ff_d = vec_q;
          end
        end
        if (abort_i) begin
          stim_d  = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (vec_q == VecLast) begin
          stim_d  = '0;
          busy_d  = 1'b0;
          state_d = StDone;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          stim_d  = vec_q + N_IN'(1);
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end
      end

      StDone: begin
        stim_d  = '0;
        busy_d  = 1'b0;
        mism_d  = (mcnt_q != '0);
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      ones_q  <= '0;
      mcnt_q  <= '0;
      ff_q    <= '0;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
      mcnt_q  <= mcnt_d;
      ff_q    <= ff_d;
      mism_q  <= mism_d;
    end
  end

  assign stim_out_o     = stim_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign truth_table_o  = tt_q;
  assign ones_count_o   = ones_q;
  assign mismatch_cnt_o = mcnt_q;
  assign first_fail_o   = ff_q;
  assign mismatch_o     = mism_q;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Directed testbench for logic_sweep_ctrl. The main instance runs with SETTLE=2; two extra
// instances with SETTLE=1 and SETTLE=3 check stimulus hold times.
module tb_logic_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, start13, tie1;
  logic [31:0] exp_table;

  logic [4:0]  stim2, stim1, stim3;
  logic        busy2, busy1, busy3, done2, done1, done3, mm2, mm1, mm3;
  logic [31:0] tt2, tt1, tt3;
  logic [5:0]  ones2, ones1, ones3, mc2, mc1, mc3;
  logic [4:0]  ff2, ff1, ff3;
  logic        z2, z1, z3;

  // Reference circuit: z = ~(e&(c^d)) | ((a&b|c)&~d)
  function automatic logic circ(input logic [4:0] v);
    return ~(v[4] & (v[2] ^ v[3])) | (((v[0] & v[1]) | v[2]) & ~v[3]);
  endfunction

  assign z2 = tie1 | circ(stim2);
  assign z1 = circ(stim1);
  assign z3 = circ(stim3);

  logic_sweep_ctrl #(.N_IN(5), .SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .exp_table_i(exp_table),
    .dut_z_i(z2), .stim_out_o(stim2), .busy_o(busy2), .done_o(done2), .truth_table_o(tt2),
    .ones_count_o(ones2), .mismatch_cnt_o(mc2), .first_fail_o(ff2), .mismatch_o(mm2)
  );

  logic_sweep_ctrl #(.N_IN(5), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start_i(start13), .abort_i(1'b0), .exp_table_i(exp_table),
    .dut_z_i(z1), .stim_out_o(stim1), .busy_o(busy1), .done_o(done1), .truth_table_o(tt1),
    .ones_count_o(ones1), .mismatch_cnt_o(mc1), .first_fail_o(ff1), .mismatch_o(mm1)
  );

  logic_sweep_ctrl #(.N_IN(5), .SETTLE(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .start_i(start13), .abort_i(1'b0), .exp_table_i(exp_table),
    .dut_z_i(z3), .stim_out_o(stim3), .busy_o(busy3), .done_o(done3), .truth_table_o(tt3),
    .ones_count_o(ones3), .mismatch_cnt_o(mc3), .first_fail_o(ff3), .mismatch_o(mm3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges after the start edge until done2 is seen, -1 if never.
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done2) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic start_sweep(input logic [31:0] exp);
    exp_table = exp;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  int lat, found, err1, err3, dcnt, d1, d2;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start13 = 1'b0; tie1 = 1'b0;
    exp_table = '0;
    #12;
    check_eq("rst_stim", 64'(stim2), 64'd0);
    check_eq("rst_busy", 64'(busy2), 64'd0);
    check_eq("rst_done", 64'(done2), 64'd0);
    check_eq("rst_tt", 64'(tt2), 64'd0);
    check_eq("rst_mm", 64'(mm2), 64'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a sweep, at vector 10
    start_sweep(32'hF0FF_FFFF);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (stim2 == 5'd10) begin
        found = 1;
        break;
      end
      tick();
    end
    check_eq("t1_reach_v10", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1_async_stim", 64'(stim2), 64'd0);
    check_eq("t1_async_tt", 64'(tt2), 64'd0);
    check_eq("t1_async_ones", 64'(ones2), 64'd0);
    check_eq("t1_async_busy", 64'(busy2), 64'd0);
    check_eq("t1_async_done", 64'(done2), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t1_idle_busy", 64'(busy2), 64'd0);

    // Default circuit, matching expected table
    start_sweep(32'hF0FF_FFFF);
    wait_done(150, lat);
    check_eq("t2_done_lat", 64'(lat), 64'd97);
    check_eq("t2_tt", 64'(tt2), 64'hF0FF_FFFF);
    check_eq("t2_ones", 64'(ones2), 64'd28);
    check_eq("t2_mc", 64'(mc2), 64'd0);
    check_eq("t2_ff", 64'(ff2), 64'd0);
    check_eq("t2_mm", 64'(mm2), 64'd0);
    check_eq("t2_busy", 64'(busy2), 64'd0);
    tick();
    check_eq("t2_done_width", 64'(done2), 64'd0);

    // Same circuit, all-ones expected table: vectors 24..27 fail
    start_sweep(32'hFFFF_FFFF);
    wait_done(150, lat);
    check_eq("t3_done_lat", 64'(lat), 64'd97);
    check_eq("t3_tt", 64'(tt2), 64'hF0FF_FFFF);
    check_eq("t3_mc", 64'(mc2), 64'd4);
    check_eq("t3_ff", 64'(ff2), 64'd24);
    check_eq("t3_mm", 64'(mm2), 64'd1);
    tick();

    // Stimulus hold times for SETTLE=1 (2 cycles/vector) and SETTLE=3 (4 cycles/vector)
    exp_table = 32'hF0FF_FFFF;
    start13 = 1'b1;
    tick();
    start13 = 1'b0;
    err1 = 0;
    err3 = 0;
    for (int j = 0; j < 128; j++) begin
      if (j < 64 && stim1 != 5'(j / 2)) err1++;
      if (stim3 != 5'(j / 4)) err3++;
      tick();
    end
    check_eq("t4_s1_seq_err", 64'(err1), 64'd0);
    check_eq("t4_s3_seq_err", 64'(err3), 64'd0);
    for (int j = 0; j < 5; j++) tick();
    check_eq("t4_s1_tt", 64'(tt1), 64'hF0FF_FFFF);
    check_eq("t4_s3_tt", 64'(tt3), 64'hF0FF_FFFF);
    check_eq("t4_s3_ones", 64'(ones3), 64'd28);

    // Abort in SAMPLE of vector 5 with z tied high; a busy start must change nothing
    tie1 = 1'b1;
    start_sweep(32'hFFFF_FFFF);
    for (int j = 0; j < 5; j++) tick();
    exp_table = 32'h0000_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 6; j < 17; j++) tick();
    check_eq("t5_pre_busy", 64'(busy2), 64'd1);
    check_eq("t5_pre_stim", 64'(stim2), 64'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t5_busy", 64'(busy2), 64'd0);
    check_eq("t5_stim", 64'(stim2), 64'd0);
    check_eq("t5_tt", 64'(tt2), 64'h0000_003F);
    check_eq("t5_ones", 64'(ones2), 64'd6);
    check_eq("t5_mc", 64'(mc2), 64'd0);
    check_eq("t5_mm_held", 64'(mm2), 64'd1);
    dcnt = 0;
    for (int j = 0; j < 110; j++) begin
      if (done2) dcnt++;
      tick();
    end
    check_eq("t5_no_done", 64'(dcnt), 64'd0);

    // start and abort together in idle: no sweep, results held
    tie1 = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    dcnt = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (busy2 || done2) dcnt++;
    end
    start = 1'b0;
    abort = 1'b0;
    check_eq("t6_no_sweep", 64'(dcnt), 64'd0);
    check_eq("t6_tt_held", 64'(tt2), 64'h0000_003F);

    // start held high: back-to-back sweeps
    exp_table = 32'hF0FF_FFFF;
    start = 1'b1;
    tick();
    d1 = -1;
    d2 = -1;
    for (int i = 1; i <= 250; i++) begin
      tick();
      if (done2) begin
        if (d1 < 0) d1 = i;
        else begin
          d2 = i;
          break;
        end
      end
    end
    start = 1'b0;
    check_eq("t6_first_done", 64'(d1), 64'd97);
    check_eq("t6_done_gap", 64'(d2 - d1), 64'd98);
    tick();
    check_eq("t6_tt", 64'(tt2), 64'hF0FF_FFFF);
    check_eq("t6_idle", 64'(busy2), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
